alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor of the combinational 16-bit ALU.
- WIDTH is a parameter; the opcode grows to 3 bits (8 ops), N/Z/C/V flags are added, and a multi-cycle shift-add unsigned multiplier is included.
- A start/busy/done handshake lets the CPU control unit stall on multi-cycle ops.
- Sits in the execute stage between the register file read and writeback.

Parameters:
WIDTH  16  data width of srcA, srcB, ALUresult (>=4, power of 2)

Ports:
clk        input   1            clock, rising edge
rst        input   1            asynchronous active-low reset
start      input   1            request; sampled only while not busy
ALUop      input   3            operation select
srcA       input   WIDTH        operand A
srcB       input   WIDTH        operand B
ALUresult  output  WIDTH        registered result
flags      output  4            {N,Z,C,V}, registered with ALUresult
busy       output  1            high while a multiply is in progress
done       output  1            one-cycle pulse: ALUresult/flags valid

Behaviour:
- Reset (rst=0, async): state=IDLE; ALUresult=0; flags=0; busy=0; done=0; internal accumulator/counter cleared. A reset mid-multiply abandons the operation; no done pulse.
- ALUop encoding:
  - 000 sub (A-B)
  - 001 add (A+B)
  - 010 and
  - 011 or
  - 100 xor
  - 101 shl (A << B[log2(WIDTH)-1:0])
  - 110 mul (unsigned, low WIDTH bits)
  - 111 shr logical (A >> B[log2(WIDTH)-1:0])
- States: IDLE, MUL.
- IDLE, start=1, ALUop!=110:
  - Result and flags are registered at the sampling edge.
  - done=1 for the following cycle. Latency 1.
  - State stays IDLE; busy stays 0.
- IDLE, start=1, ALUop=110:
  - Capture mcand=zero-extended A (2*WIDTH bits), mplier=B, acc=0, count=0.
  - Go to MUL; busy=1 from the next cycle.
- MUL, each edge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - On the edge where count reaches WIDTH: ALUresult=acc_final[WIDTH-1:0], flags written, done=1 for the next cycle, busy=0, state=IDLE.
  - Total latency from the start edge to done high: WIDTH+1 edges (done high in cycle WIDTH+1 after start).
- start while busy=1: ignored; operands and ALUop are not captured.
- start=1 during a cycle with done=1 (state IDLE): accepted; back-to-back throughput is 1 op/cycle for single-cycle ops.
- ALUresult/flags hold their last value until the next completion; done=0 otherwise.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0) for every op.
  - add: C = carry out; V = signed overflow (A,B same sign, result sign differs).
  - sub: C = 1 when no borrow (A>=B unsigned); V = signed overflow (A,B signs differ, result sign != A sign).
  - and/or/xor: C=0, V=0.
  - shl: C = last bit shifted out (A[WIDTH-amt]); shr: C = A[amt-1]; shift amount 0 gives C=0. V=0 for both shifts.
  - mul: C = 1 if product bits [2*WIDTH-1:WIDTH] are nonzero (unsigned overflow); V=0.
- All arithmetic wraps modulo 2^WIDTH.
- Shift amount uses only the low log2(WIDTH) bits of B; upper bits are ignored.

Test Plan:
- Reset then idle, WIDTH=16 → ALUresult=0, flags=0, busy=0, done=0. Then sub 5-2 → done one cycle after start, ALUresult=3, flags=0010 (C=1, no borrow). Then 2-5 → 0xFFFD, N=1, C=0.
- add 0xFFFF+0x0001 → 0x0000, flags=0110 (Z,C). Then add 0x7FFF+1 → 0x8000, flags=1001 (N,V).
- mul 300*300 → busy=1 for 16 cycles; done in the 17th cycle after the start edge; ALUresult=0x5F90; C=1. Then mul 7*6 → 42, C=0.
- start with add 1+1 on the second cycle of a busy mul → ignored. The mul result 0x5F90 is unchanged and exactly one done pulse occurs.
- shl 0x8001 by B=0x0011 (amt=1) → 0x0002, C=1. Then shr 0x0003 by 1 → 0x0001, C=1. Then shl by 0 → A unchanged, C=0.
- Pull rst low 5 cycles into a mul, then release → all outputs 0, no done pulse, state IDLE. A subsequent add 2+3 completes with result 5 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with N/Z/C/V flags and a multi-cycle shift-add unsigned multiplier.
// Single-cycle ops complete in one edge; mul holds busy for WIDTH cycles.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] ALUresult,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam logic [LW:0] CntLast = WIDTH[LW:0];

    localparam logic [2:0] OpSub = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    typedef enum logic {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flags_q, flags_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [LW:0]          count_q, count_d;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [LW-1:0]        amt;
    logic [WIDTH:0]       shl_w, shr_w;
    logic [2*WIDTH-1:0]   acc_step;
    logic [LW:0]          count_inc;

    // The extra bit on each shift catches the last bit shifted out (zero when amt is 0).
    assign amt   = srcB[LW-1:0];
    assign shl_w = {1'b0, srcA} << amt;
    assign shr_w = {srcA, 1'b0} >> amt;

    always_comb begin
        sum_w   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (ALUop)
            OpSub: begin
                // A + ~B + 1: carry out is the "no borrow" flag.
                sum_w   = {1'b0, srcA} + {1'b0, ~srcB} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (srcA[WIDTH-1] != srcB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != srcA[WIDTH-1]);
            end
            OpAdd: begin
                sum_w   = {1'b0, srcA} + {1'b0, srcB};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != srcA[WIDTH-1]);
            end
            OpAnd: alu_res = srcA & srcB;
            OpOr:  alu_res = srcA | srcB;
            OpXor: alu_res = srcA ^ srcB;
            OpShl: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OpMul: alu_res = '0;
            OpShr: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
        endcase
    end

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (ALUop == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, srcA};
                        mplier_d = srcB;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_res;
                        flags_d  = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_inc;
                if (count_inc == CntLast) begin
                    result_d = acc_step[WIDTH-1:0];
                    flags_d  = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                                |acc_step[2*WIDTH-1:WIDTH], 1'b0};
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign ALUresult = result_q;
    assign flags     = flags_q;
    assign done      = done_q;
    assign busy      = (state_q == StMul);

endmodule
